// File: rtl/fsm_serial_tx.sv
// Moore serial frame transmitter: start bit, MSB-first data, optional parity, stop bit.
// Every bit is held for BIT_CYCLES clocks; all outputs are registered.
module fsm_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               last_cycle;
    logic               tx_out_d;

    assign last_cycle = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d  = StStart;
                    cnt_d    = '0;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ PARITY_ODD[0];
                end
            end
            StStart: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    shift_d = shift_q << 1;
                    if (idx_q == '0) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unencoded state: recover to a clean idle.
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch together with it.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            StStart:  tx_out_d = 1'b0;
            StData:   tx_out_d = shift_d[WIDTH-1];
            StParity: tx_out_d = parity_d;
            default:  tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out     <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_out     <= tx_out_d;
            tx_ready   <= (state_d == StIdle);
            tx_busy    <= (state_d != StIdle);
            frame_done <= (state_d == StStop) && (cnt_d == CNT_LAST);
        end
    end

endmodule
